// File: rtl/wb_memtest_master.sv
// rtl/wb_memtest_master.sv - Wishbone master that fills a word range with an LFSR pattern and reads it back.
// Single classic transfers with one idle cycle between them; a per-transfer ack timeout aborts the run.
module wb_memtest_master #(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int unsigned WORDS    = 1024,
  parameter logic [31:0] SEED     = 32'h0000_0001,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] first_err_adr,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
  localparam logic [23:0] LAST_IDX = 24'(WORDS - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [23:0] idx_q, idx_d;
  logic        stb_q, stb_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] first_err_adr_q, first_err_adr_d;

  logic [31:0] lfsr_next;
  logic [31:0] cur_adr;
  logic        ack;
  logic        to_hit;
  logic        last_word;

  assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign cur_adr   = BASE_ADR + {6'd0, idx_q, 2'b00};
  assign last_word = (idx_q == LAST_IDX);
  // An ack outside an active strobe is not part of any transfer and is dropped here.
  assign ack       = stb_q & wb_ack_i;
  // Ack on the final allowed cycle still completes the transfer.
  assign to_hit    = stb_q & ~wb_ack_i & (to_cnt_q == TO_LAST);

  always_comb begin
    state_d         = state_q;
    lfsr_d          = lfsr_q;
    idx_d           = idx_q;
    stb_d           = stb_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    pass_d          = pass_q;
    timeout_d       = timeout_q;
    err_count_d     = err_count_q;
    first_err_adr_d = first_err_adr_q;
    to_cnt_d        = (stb_q && !wb_ack_i) ? to_cnt_q + 16'd1 : 16'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_count_d     = 16'd0;
          first_err_adr_d = 32'd0;
          timeout_d       = 1'b0;
          pass_d          = 1'b0;
          lfsr_d          = SEED_EFF;
          idx_d           = 24'd0;
          busy_d          = 1'b1;
          stb_d           = 1'b1;
          state_d         = S_WR;
        end
      end

      S_WR: begin
        if (to_hit) begin
          timeout_d = 1'b1;
          stb_d     = 1'b0;
          state_d   = S_FIN;
        end else if (ack) begin
          stb_d = 1'b0;
          if (last_word) begin
            lfsr_d  = SEED_EFF;
            idx_d   = 24'd0;
            state_d = S_RD;
          end else begin
            lfsr_d = lfsr_next;
            idx_d  = idx_q + 24'd1;
          end
        end else if (!stb_q) begin
          stb_d = 1'b1;
        end
      end

      S_RD: begin
        if (to_hit) begin
          timeout_d = 1'b1;
          stb_d     = 1'b0;
          state_d   = S_FIN;
        end else if (ack) begin
          stb_d = 1'b0;
          if (wb_dat_i != lfsr_q) begin
            if (err_count_q != 16'hFFFF) begin
              err_count_d = err_count_q + 16'd1;
            end
            if (err_count_q == 16'd0) begin
              first_err_adr_d = cur_adr;
            end
          end
          lfsr_d = lfsr_next;
          idx_d  = idx_q + 24'd1;
          if (last_word) begin
            state_d = S_FIN;
          end
        end else if (!stb_q) begin
          stb_d = 1'b1;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_count_q == 16'd0) && !timeout_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      lfsr_q          <= SEED_EFF;
      idx_q           <= 24'd0;
      stb_q           <= 1'b0;
      to_cnt_q        <= 16'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      timeout_q       <= 1'b0;
      err_count_q     <= 16'd0;
      first_err_adr_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      idx_q           <= idx_d;
      stb_q           <= stb_d;
      to_cnt_q        <= to_cnt_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      timeout_q       <= timeout_d;
      err_count_q     <= err_count_d;
      first_err_adr_q <= first_err_adr_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign err_count     = err_count_q;
  assign first_err_adr = first_err_adr_q;

  // Address/data/select are forced to zero between transfers so the bus is quiet when idle.
  assign wb_cyc_o = stb_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = stb_q && (state_q == S_WR);
  assign wb_adr_o = stb_q ? cur_adr : 32'd0;
  assign wb_sel_o = stb_q ? 4'hF : 4'h0;
  assign wb_dat_o = (stb_q && (state_q == S_WR)) ? lfsr_q : 32'd0;

endmodule

// File: tb/tb_wb_memtest_master.sv
// tb/tb_wb_memtest_master.sv - Self-checking bench for wb_memtest_master.
// Two DUT configurations share one RAM slave model selected by sel.
module tb_wb_memtest_master;

  localparam int unsigned A_WORDS = 16;
  localparam logic [31:0] A_BASE  = 32'h0000_0000;
  localparam logic [31:0] A_SEED  = 32'h0000_0001;
  localparam int unsigned A_TO    = 10;
  localparam int unsigned B_WORDS = 64;
  localparam logic [31:0] B_BASE  = 32'hFFFF_FF80;
  localparam logic [31:0] B_SEED  = 32'h0000_0000;
  localparam int unsigned B_TO    = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic sel = 1'b0;

  logic        a_busy, a_done, a_pass, a_to, a_cyc, a_stb, a_we;
  logic [15:0] a_err;
  logic [31:0] a_first, a_adr, a_wdat;
  logic [3:0]  a_sel;
  logic        b_busy, b_done, b_pass, b_to, b_cyc, b_stb, b_we;
  logic [15:0] b_err;
  logic [31:0] b_first, b_adr, b_wdat;
  logic [3:0]  b_sel;

  logic        s_ack = 1'b0;
  logic [31:0] s_dat = 32'h0;

  always #5 clk = ~clk;

  wb_memtest_master #(.BASE_ADR(A_BASE), .WORDS(A_WORDS), .SEED(A_SEED), .TIMEOUT(A_TO)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done), .pass(a_pass),
    .timeout(a_to), .err_count(a_err), .first_err_adr(a_first), .wb_cyc_o(a_cyc),
    .wb_stb_o(a_stb), .wb_we_o(a_we), .wb_adr_o(a_adr), .wb_sel_o(a_sel), .wb_dat_o(a_wdat),
    .wb_dat_i(sel ? 32'h0 : s_dat), .wb_ack_i(sel ? 1'b0 : s_ack)
  );

  wb_memtest_master #(.BASE_ADR(B_BASE), .WORDS(B_WORDS), .SEED(B_SEED), .TIMEOUT(B_TO)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done), .pass(b_pass),
    .timeout(b_to), .err_count(b_err), .first_err_adr(b_first), .wb_cyc_o(b_cyc),
    .wb_stb_o(b_stb), .wb_we_o(b_we), .wb_adr_o(b_adr), .wb_sel_o(b_sel), .wb_dat_o(b_wdat),
    .wb_dat_i(sel ? s_dat : 32'h0), .wb_ack_i(sel ? s_ack : 1'b0)
  );

  wire        m_cyc  = sel ? b_cyc : a_cyc;
  wire        m_stb  = sel ? b_stb : a_stb;
  wire        m_we   = sel ? b_we : a_we;
  wire [31:0] m_adr  = sel ? b_adr : a_adr;
  wire [31:0] m_wdat = sel ? b_wdat : a_wdat;
  wire [3:0]  m_sel  = sel ? b_sel : a_sel;
  wire        m_busy = sel ? b_busy : a_busy;
  wire        m_done = sel ? b_done : a_done;
  wire        m_pass = sel ? b_pass : a_pass;
  wire        m_to   = sel ? b_to : a_to;
  wire [15:0] m_err  = sel ? b_err : a_err;
  wire [31:0] m_first = sel ? b_first : a_first;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model and bus monitor state
  logic [31:0] mem [logic [31:0]];
  int unsigned max_delay = 0, delay = 0, wait_cnt = 0;
  bit          no_ack = 0, flip_en = 0;
  logic [31:0] flip_adr = 32'h0;
  logic [31:0] wr_adr_q[$], wr_dat_q[$], rd_adr_q[$];
  int          done_cnt, gap_bad, proto_bad, stb_drop, stb_run, last_run, idle_cnt;
  bit          prev_stb, prev_ack, after_ack;

  task automatic mon_clear();
    mem.delete();
    wr_adr_q.delete();
    wr_dat_q.delete();
    rd_adr_q.delete();
    done_cnt = 0; gap_bad = 0; proto_bad = 0; stb_drop = 0;
    stb_run = 0; last_run = 0; idle_cnt = 0;
    prev_stb = 0; prev_ack = 0; after_ack = 0;
    wait_cnt = 0;
    delay = $urandom_range(max_delay, 0);
  endtask

  always @(negedge clk) begin
    s_ack = 1'b0;
    s_dat = 32'h0;
    if (m_stb && !no_ack) begin
      if (wait_cnt >= delay) begin
        s_ack = 1'b1;
        if (m_we) begin
          mem[m_adr] = m_wdat;
        end else begin
          s_dat = mem.exists(m_adr) ? mem[m_adr] : 32'hFFFF_FFFF;
          if (flip_en && m_adr == flip_adr) s_dat = s_dat ^ 32'h1;
        end
        wait_cnt = 0;
        delay = $urandom_range(max_delay, 0);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end

    if (m_stb) begin
      if (!m_cyc || m_sel != 4'hF) proto_bad++;
      if (prev_ack) gap_bad++;
      if (!prev_stb && after_ack && idle_cnt != 1) gap_bad++;
      stb_run++;
      if (s_ack) begin
        if (m_we) begin
          wr_adr_q.push_back(m_adr);
          wr_dat_q.push_back(m_wdat);
        end else begin
          rd_adr_q.push_back(m_adr);
        end
        after_ack = 1;
        idle_cnt = 0;
      end
    end else begin
      if (prev_stb && !prev_ack) begin
        stb_drop++;
        last_run = stb_run;
      end
      stb_run = 0;
      if (after_ack) idle_cnt++;
      if (m_cyc || m_we || m_sel != 4'h0) proto_bad++;
    end
    if (m_done) done_cnt++;
    prev_stb = m_stb;
    prev_ack = m_stb && s_ack;
  end

  // Reference pattern: word i is the seed advanced i LFSR steps
  logic [31:0] exp_a[A_WORDS];
  logic [31:0] exp_b[B_WORDS];

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  function automatic logic [31:0] exp_word(input bit which, input int k);
    return which ? exp_b[k] : exp_a[k];
  endfunction

  typedef struct {
    bit          dut;
    int unsigned max_delay;
    bit          no_ack;
    bit          mid_start;
    bit          flip_en;
    logic [31:0] flip_adr;
    bit          exp_pass;
    logic [15:0] exp_err;
    logic [31:0] exp_first;
    bit          exp_to;
    int          exp_writes;
    int          exp_reads;
  } vec_t;

  vec_t vecs[7];

  task automatic pulse_start(input bit which);
    @(posedge clk); #1;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int          words;
    logic [31:0] base;
    bit          got;
    int          bad;
    sel = v.dut;
    max_delay = v.max_delay;
    no_ack = v.no_ack;
    flip_en = v.flip_en;
    flip_adr = v.flip_adr;
    words = v.dut ? int'(B_WORDS) : int'(A_WORDS);
    base = v.dut ? B_BASE : A_BASE;
    mon_clear();
    pulse_start(v.dut);
    check($sformatf("v%0d_busy_after_start", id), m_busy, 1);
    if (v.mid_start) begin
      for (int c = 0; c < 5000; c++) begin
        @(negedge clk);
        if (wr_adr_q.size() >= 5) break;
      end
      pulse_start(v.dut);
    end
    got = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (m_done) begin
        got = 1;
        break;
      end
    end
    check($sformatf("v%0d_done_seen", id), got, 1);
    check($sformatf("v%0d_busy_at_done", id), m_busy, 0);
    check($sformatf("v%0d_pass", id), m_pass, v.exp_pass);
    check($sformatf("v%0d_err_count", id), m_err, v.exp_err);
    check($sformatf("v%0d_first_err_adr", id), m_first, v.exp_first);
    check($sformatf("v%0d_timeout", id), m_to, v.exp_to);
    repeat (5) @(negedge clk);
    check($sformatf("v%0d_done_pulses", id), done_cnt, 1);
    check($sformatf("v%0d_pass_hold", id), m_pass, v.exp_pass);
    check($sformatf("v%0d_writes", id), wr_adr_q.size(), v.exp_writes);
    check($sformatf("v%0d_reads", id), rd_adr_q.size(), v.exp_reads);
    bad = 0;
    for (int k = 0; k < wr_adr_q.size() && k < words; k++)
      if (wr_adr_q[k] !== base + 32'(4 * k) || wr_dat_q[k] !== exp_word(v.dut, k)) bad++;
    check($sformatf("v%0d_wr_seq", id), bad, 0);
    bad = 0;
    for (int k = 0; k < rd_adr_q.size(); k++)
      if (rd_adr_q[k] !== base + 32'(4 * k)) bad++;
    check($sformatf("v%0d_rd_seq", id), bad, 0);
    check($sformatf("v%0d_gap", id), gap_bad, 0);
    check($sformatf("v%0d_proto", id), proto_bad, 0);
    check($sformatf("v%0d_stb_drop", id), stb_drop, v.no_ack ? 1 : 0);
    if (v.no_ack) check($sformatf("v%0d_stb_len", id), last_run, A_TO);
    if (wr_dat_q.size() >= 2 && !v.dut) begin
      check($sformatf("v%0d_word0", id), wr_dat_q[0], 32'h0000_0001);
      check($sformatf("v%0d_word1", id), wr_dat_q[1], 32'h0000_0003);
    end
    if (wr_dat_q.size() >= 1 && v.dut) check($sformatf("v%0d_seed0_word0", id), wr_dat_q[0], 32'h0000_0001);
  endtask

  initial begin
    logic [31:0] w;
    bit          got;
    w = A_SEED;
    for (int i = 0; i < int'(A_WORDS); i++) begin exp_a[i] = w; w = lfsr_step(w); end
    w = 32'h0000_0001;
    for (int i = 0; i < int'(B_WORDS); i++) begin exp_b[i] = w; w = lfsr_step(w); end

    //        dut dly noack mid  flip  flip_adr       pass err    first          to  wr  rd
    vecs[0] = '{0, 0, 0, 0, 0, 32'h0,          1, 16'd0, 32'h0,          0, 16, 16};
    vecs[1] = '{0, 0, 0, 0, 1, 32'h0000_0014,  0, 16'd1, 32'h0000_0014,  0, 16, 16};
    vecs[2] = '{1, 7, 0, 0, 0, 32'h0,          1, 16'd0, 32'h0,          0, 64, 64};
    vecs[3] = '{1, 3, 0, 0, 1, 32'h0000_0004,  0, 16'd1, 32'h0000_0004,  0, 64, 64};
    vecs[4] = '{0, 0, 1, 0, 0, 32'h0,          0, 16'd0, 32'h0,          1, 0,  0};
    vecs[5] = '{0, 2, 0, 1, 0, 32'h0,          1, 16'd0, 32'h0,          0, 16, 16};
    vecs[6] = '{0, 1, 0, 0, 0, 32'h0,          1, 16'd0, 32'h0,          0, 16, 16};

    mon_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_a", {a_busy, a_done, a_pass, a_to, a_err, a_first, a_cyc, a_stb, a_we, a_adr, a_sel, a_wdat}, 0);
    check("reset_outputs_b", {b_busy, b_done, b_pass, b_to, b_err, b_first, b_cyc, b_stb, b_we, b_adr, b_sel, b_wdat}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset during write 3, then a clean rerun from the base address
    sel = 1'b0; max_delay = 0; no_ack = 0; flip_en = 0;
    mon_clear();
    pulse_start(1'b0);
    got = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (a_stb && a_we && a_adr == 32'h0000_000C) begin
        got = 1;
        break;
      end
    end
    check("rst_reached_write3", got, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_cyc_drop", {a_cyc, a_stb}, 0);
    check("rst_busy_clear", a_busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    done_cnt = 0;
    repeat (10) @(negedge clk);
    check("rst_no_done", done_cnt, 0);
    run_vec(vecs[0], 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
